// File: rtl/seg_pkg.sv
// Shared types and constants for the tick counter display: count modes,
// the active-low 7-segment hex table and the decimal digit clamp.
package seg_pkg;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // bit0 = segment a, active-low
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [3:0] clamp_dec(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider: counts 0..TICK_DIV-1 while enabled and emits a
// combinational tick in the wrap cycle; clr restarts the interval and masks the tick.
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic in_clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            if (div_q == LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + W'(1);
            end
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/seg_tick_counter.sv
// Tick counter (hex or BCD, up/down, loadable) driving active-low 7-segment
// displays and a blink LED bank. Define SEG_LEAD_BLANK_EN to blank leading zero digits.
module seg_tick_counter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50_000_000,
    parameter int LED_WIDTH  = 10
) (
    input  logic                    in_clk,
    input  logic                    reset,
    input  logic                    in_run,
    input  logic                    in_dir,
    input  logic                    in_mode,
    input  logic                    in_load,
    input  logic [4*NUM_DIGITS-1:0] in_load_val,
    output logic                    out_tick,
    output logic [4*NUM_DIGITS-1:0] out_count,
    output logic [LED_WIDTH-1:0]    out_led,
    output logic [7*NUM_DIGITS-1:0] out_seg
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int SW = 7 * NUM_DIGITS;

    function automatic logic [SW-1:0] seg_reset_val();
        logic [SW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG_LEAD_BLANK_EN
            v[7*i +: 7] = (i == 0) ? SEG_HEX[0] : SEG_BLANK;
`else
            v[7*i +: 7] = SEG_HEX[0];
`endif
        end
        return v;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_reset_val();

    logic [CW-1:0] count_q, count_d;
    logic          latch_q, latch_d;
    logic          tick_q, tick_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] seg_q, seg_d;

    logic          tick;
    logic          mode_chg;
    logic          dec_mode;
    logic [CW-1:0] step;
    logic [CW-1:0] load_val;
    logic [3:0]    dig;
    logic [3:0]    lim;
    logic          carry;

    assign dec_mode = (mode_e'(in_mode) == MODE_DEC);
    assign mode_chg = (in_mode != mode_q);

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .in_clk (in_clk),
        .reset  (reset),
        .en     (in_run),
        .clr    (in_load | mode_chg),
        .tick   (tick)
    );

    // Ripple carry/borrow across digits; the digit limit selects hex or BCD wrap.
    always_comb begin
        step  = count_q;
        carry = 1'b1;
        lim   = dec_mode ? 4'd9 : 4'hF;
        dig   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (!in_dir) begin
                    if (dig >= lim) begin
                        dig = '0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = lim;
                    end else begin
                        dig   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step[4*i +: 4] = dig;
        end
    end

    always_comb begin
        load_val = in_load_val;
        if (dec_mode) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                load_val[4*i +: 4] = clamp_dec(in_load_val[4*i +: 4]);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        latch_d = latch_q;
        tick_d  = tick;
        mode_d  = in_mode;
        if (in_load) begin
            count_d = load_val;
        end else if (mode_chg) begin
            count_d = '0;
        end else if (tick) begin
            count_d = step;
            latch_d = ~latch_q;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0] hex_seg;
        assign hex_seg = SEG_HEX[count_q[4*g +: 4]];
`ifdef SEG_LEAD_BLANK_EN
        if (g == 0) begin : g_lsd
            assign seg_d[7*g +: 7] = hex_seg;
        end else begin : g_upper
            assign seg_d[7*g +: 7] = ((count_q >> (4*g)) == '0) ? SEG_BLANK : hex_seg;
        end
`else
        assign seg_d[7*g +: 7] = hex_seg;
`endif
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            latch_q <= 1'b0;
            tick_q  <= 1'b0;
            mode_q  <= MODE_HEX;
            seg_q   <= SEG_RST;
        end else begin
            count_q <= count_d;
            latch_q <= latch_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            seg_q   <= seg_d;
        end
    end

    assign out_tick  = tick_q;
    assign out_count = count_q;
    assign out_led   = {LED_WIDTH{latch_q}};
    assign out_seg   = seg_q;

endmodule

// File: tb/tb_seg_tick_counter.sv
// Scoreboard bench for seg_tick_counter (TICK_DIV=4, NUM_DIGITS=2, LED_WIDTH=10).
module tb_seg_tick_counter;

    logic        clk;
    logic        reset;
    logic        in_run;
    logic        in_dir;
    logic        in_mode;
    logic        in_load;
    logic [7:0]  in_load_val;
    logic        out_tick;
    logic [7:0]  out_count;
    logic [9:0]  out_led;
    logic [13:0] out_seg;

    seg_tick_counter #(
        .NUM_DIGITS (2),
        .TICK_DIV   (4),
        .LED_WIDTH  (10)
    ) dut (
        .in_clk      (clk),
        .reset       (reset),
        .in_run      (in_run),
        .in_dir      (in_dir),
        .in_mode     (in_mode),
        .in_load     (in_load),
        .in_load_val (in_load_val),
        .out_tick    (out_tick),
        .out_count   (out_count),
        .out_led     (out_led),
        .out_seg     (out_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  count;
        logic [9:0]  led;
        logic [13:0] seg;
    } exp_t;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

`ifdef SEG_LEAD_BLANK_EN
    localparam logic [13:0] SEG_AFTER_RESET = {7'h7F, 7'h40};
    localparam logic [13:0] SEG_05          = {7'h7F, 7'h12};
`else
    localparam logic [13:0] SEG_AFTER_RESET = {7'h40, 7'h40};
    localparam logic [13:0] SEG_05          = {7'h40, 7'h12};
`endif

    exp_t        sb[$];
    exp_t        cur;
    int          compares = 0;
    int          failures = 0;
    logic        exp_latch = 1'b0;
    logic        seg_pending = 1'b0;
    logic [13:0] pend_seg;

    function automatic logic [13:0] seg_of(input logic [7:0] c);
        logic [6:0] hi;
        hi = SEG_REF[c[7:4]];
`ifdef SEG_LEAD_BLANK_EN
        if (c[7:4] == 4'd0) hi = 7'h7F;
`endif
        return {hi, SEG_REF[c[3:0]]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_tick(input logic [7:0] c);
        exp_t e;
        exp_latch = ~exp_latch;
        e.count = c;
        e.led   = {10{exp_latch}};
        e.seg   = seg_of(c);
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] v);
        in_load     = 1'b1;
        in_load_val = v;
        @(posedge clk); #1;
        in_load     = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || seg_pending) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || seg_pending) begin
            compares++;
            failures++;
            $display("FAIL drain_timeout: %0d ticks still pending after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
            seg_pending = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(out_count), 32'h0);
        chk({tag, "_led"},   32'(out_led),   32'h0);
        chk({tag, "_tick"},  32'(out_tick),  32'h0);
        chk({tag, "_seg"},   32'(out_seg),   32'(SEG_AFTER_RESET));
    endtask

    // Monitor: every out_tick pulse consumes one expectation; segments follow a cycle later.
    always @(negedge clk) begin
        if (reset) begin
            seg_pending = 1'b0;
        end else begin
            if (seg_pending) begin
                chk("tick_seg", 32'(out_seg), 32'(pend_seg));
                seg_pending = 1'b0;
            end
            if (out_tick) begin
                if (sb.size() == 0) begin
                    compares++;
                    failures++;
                    $display("FAIL unexpected_tick: tick with count %0h, expected no tick", out_count);
                end else begin
                    cur = sb.pop_front();
                    chk("tick_count", 32'(out_count), 32'(cur.count));
                    chk("tick_led",   32'(out_led),   32'(cur.led));
                    pend_seg    = cur.seg;
                    seg_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        in_run      = 1'b0;
        in_dir      = 1'b0;
        in_mode     = 1'b0;
        in_load     = 1'b0;
        in_load_val = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Hex count up through 16 ticks
        for (int i = 1; i <= 16; i++) push_tick(8'(i));
        in_run = 1'b1;
        drain(16 * 4 + 20);
        in_run = 1'b0;
        chk("hex_16_count", 32'(out_count), 32'h10);
        chk("hex_16_seg",   32'(out_seg),   32'({7'h79, 7'h40}));

        // Hex wrap 0xFF -> 0x00
        do_load(8'hFF);
        chk("load_ff_count", 32'(out_count), 32'hFF);
        chk("load_ff_led",   32'(out_led),   32'({10{exp_latch}}));
        push_tick(8'h00);
        in_run = 1'b1;
        drain(20);
        in_run = 1'b0;

        // Decimal mode entered together with a load of 0x99
        in_mode = 1'b1;
        do_load(8'h99);
        chk("dec_load_99", 32'(out_count), 32'h99);
        push_tick(8'h00);
        in_run = 1'b1;
        drain(20);
        in_run = 1'b0;
        in_dir = 1'b1;
        push_tick(8'h99);
        in_run = 1'b1;
        drain(20);
        in_run = 1'b0;
        do_load(8'h10);
        push_tick(8'h09);
        in_run = 1'b1;
        drain(20);
        in_run = 1'b0;
        do_load(8'hAB);
        chk("dec_clamp_ab", 32'(out_count), 32'h99);
        do_load(8'h5C);
        chk("dec_clamp_5c", 32'(out_count), 32'h59);

        // Mode change without load clears the count
        in_mode = 1'b0;
        @(posedge clk); #1;
        chk("mode_chg_clear", 32'(out_count), 32'h00);

        // Pause with divider at 2, then resume: tick two cycles later
        in_dir = 1'b0;
        in_run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_run = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pause_count", 32'(out_count), 32'h00);
        chk("pause_led",   32'(out_led),   32'({10{exp_latch}}));
        push_tick(8'h01);
        in_run = 1'b1;
        @(posedge clk); #1;
        chk("resume_no_tick_yet", 32'(out_tick), 32'h0);
        @(posedge clk); #1;
        chk("resume_tick",       32'(out_tick),  32'h1);
        chk("resume_tick_count", 32'(out_count), 32'h01);
        in_run = 1'b0;
        drain(10);

        // Load at divider=3 wins over the tick
        @(posedge clk); #1;
        in_run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_load     = 1'b1;
        in_load_val = 8'h42;
        @(posedge clk); #1;
        in_load = 1'b0;
        chk("load42_count", 32'(out_count), 32'h42);
        chk("load42_tick",  32'(out_tick),  32'h0);
        chk("load42_led",   32'(out_led),   32'({10{exp_latch}}));
        push_tick(8'h43);
        repeat (3) @(posedge clk);
        #1;
        chk("load42_hold_count", 32'(out_count), 32'h42);
        chk("load42_hold_tick",  32'(out_tick),  32'h0);
        @(posedge clk); #1;
        chk("load42_next_tick",  32'(out_tick),  32'h1);
        chk("load42_next_count", 32'(out_count), 32'h43);
        in_run = 1'b0;
        drain(10);

        // Leading-digit display for 0x05
        do_load(8'h05);
        @(posedge clk); #1;
        chk("seg05_count", 32'(out_count), 32'h05);
        chk("seg05_seg",   32'(out_seg),   32'(SEG_05));

        // Reset mid-count returns to the reset state immediately
        push_tick(8'h06);
        in_run = 1'b1;
        drain(20);
        in_run = 1'b0;
        chk("pre_reset_led", 32'(out_led), 32'({10{exp_latch}}));
        @(posedge clk); #3;
        reset     = 1'b1;
        exp_latch = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
        $finish;
    end

endmodule
